// File: rtl/dequantize_rescale.sv
// dequantize_rescale: int8 activation -> int32 accumulator-domain rescaler.
// Three-stage stallable pipeline: offset + pre-shift, Q31 high-word multiply,
// rounding right shift. Define DEQ_SAT_EN to saturate the pre-shift and the
// (-1.0 x -1.0) multiply corner instead of wrapping.
//
// Handshake: a beat moves on in_valid & in_ready, and out on out_valid & out_ready.
// in_ready = adv = out_ready | ~out_valid; every stage advances together on adv
// and holds otherwise, so out_data/out_last are stable while stalled.
module dequantize_rescale #(
  parameter int FRAME_CNT_W = 16,
  parameter int SHIFT_MAX   = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  input  logic [31:0]            in_offset,
  input  logic [31:0]            in_multi,
  input  logic [31:0]            in_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic                   out_last,
  output logic [FRAME_CNT_W-1:0] elem_cnt,
  output logic                   busy
);

  localparam int SH_W = $clog2(SHIFT_MAX + 1);

  logic                   adv;
  logic                   accept;

  // Stage 0 register: pre-shifted value plus the config it travels with.
  logic                   s0_valid_q, s0_valid_d;
  logic                   s0_last_q, s0_last_d;
  logic [31:0]            s0_b_q, s0_b_d;
  logic [31:0]            s0_multi_q, s0_multi_d;
  logic [SH_W-1:0]        s0_rs_q, s0_rs_d;
  // Stage 1 register: rounded high word of the product.
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_last_q, s1_last_d;
  logic [31:0]            s1_m_q, s1_m_d;
  logic [SH_W-1:0]        s1_rs_q, s1_rs_d;
  // Output register.
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [31:0]            out_data_q, out_data_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;

  // Datapath intermediates.
  logic [31:0]            a_s0;
  logic [31:0]            neg_shift;
  logic [SH_W-1:0]        ls_s0;
  logic [SH_W-1:0]        rs_s0;
  logic [31:0]            b_s0;
`ifdef DEQ_SAT_EN
  logic [63:0]            wide_s0;
`endif
  logic [63:0]            p_s1;
  logic [31:0]            m_s1;
  logic [31:0]            mask_s2;
  logic [31:0]            rem_s2;
  logic [31:0]            thr_s2;
  logic signed [31:0]     sra_s2;
  logic [31:0]            res_s2;
  logic                   unused_bits;

  assign adv    = out_ready | ~out_valid_q;
  assign accept = in_valid & adv;

  // Stage 0 math: add offset, split the signed shift into clipped left/right amounts, pre-shift.
  always_comb begin
    a_s0      = {{24{in_data[7]}}, in_data} + in_offset;
    neg_shift = 32'd0 - in_shift;
    ls_s0     = '0;
    rs_s0     = '0;
    if (!in_shift[31]) begin
      if ($signed(in_shift) > SHIFT_MAX) ls_s0 = SH_W'(SHIFT_MAX);
      else                               ls_s0 = in_shift[SH_W-1:0];
    end else begin
      if ($signed(in_shift) < -SHIFT_MAX) rs_s0 = SH_W'(SHIFT_MAX);
      else                                rs_s0 = neg_shift[SH_W-1:0];
    end
`ifdef DEQ_SAT_EN
    wide_s0 = {{32{a_s0[31]}}, a_s0} << ls_s0;
    // In range only if every bit from 31 upward agrees with the sign.
    if ((&wide_s0[63:31]) || !(|wide_s0[63:31])) b_s0 = wide_s0[31:0];
    else b_s0 = a_s0[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    b_s0 = a_s0 << ls_s0;
`endif
  end

  // Stage 1 math: signed 32x32 product, keep the high word rounded half up.
  always_comb begin
    // Low 64 bits of a product are the same for signed or unsigned operands.
    p_s1 = {{32{s0_b_q[31]}}, s0_b_q} * {{32{s0_multi_q[31]}}, s0_multi_q};
    m_s1 = p_s1[63:32] + {31'd0, p_s1[31]};
`ifdef DEQ_SAT_EN
    if (s0_b_q == 32'h8000_0000 && s0_multi_q == 32'h8000_0000) m_s1 = 32'h7FFF_FFFF;
`endif
  end

  // Stage 2 math: arithmetic right shift with round-half-away-from-zero correction.
  always_comb begin
    mask_s2 = (32'd1 << s1_rs_q) - 32'd1;
    rem_s2  = s1_m_q & mask_s2;
    thr_s2  = (mask_s2 >> 1) + {31'd0, s1_m_q[31]};
    sra_s2  = $signed(s1_m_q) >>> s1_rs_q;
    res_s2  = sra_s2 + {31'd0, (rem_s2 > thr_s2)};
  end

  assign unused_bits = ^{neg_shift[31:SH_W], p_s1[30:0]};

  // Next state: whole pipe shifts on adv, otherwise every stage holds.
  always_comb begin
    s0_valid_d  = s0_valid_q;
    s0_last_d   = s0_last_q;
    s0_b_d      = s0_b_q;
    s0_multi_d  = s0_multi_q;
    s0_rs_d     = s0_rs_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_m_d      = s1_m_q;
    s1_rs_d     = s1_rs_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    if (adv) begin
      s0_valid_d = in_valid;
      if (in_valid) begin
        s0_last_d  = in_last;
        s0_b_d     = b_s0;
        s0_multi_d = in_multi;
        s0_rs_d    = rs_s0;
      end
      s1_valid_d = s0_valid_q;
      if (s0_valid_q) begin
        s1_last_d = s0_last_q;
        s1_m_d    = m_s1;
        s1_rs_d   = s0_rs_q;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_last_d = s1_last_q;
        out_data_d = res_s2;
      end
    end
    if (accept) cnt_d = in_last ? '0 : cnt_q + 1'b1;
  end

  // State registers, cleared asynchronously so in-flight beats are dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_b_q      <= '0;
      s0_multi_q  <= '0;
      s0_rs_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_m_q      <= '0;
      s1_rs_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_last_q   <= s0_last_d;
      s0_b_q      <= s0_b_d;
      s0_multi_q  <= s0_multi_d;
      s0_rs_q     <= s0_rs_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_m_q      <= s1_m_d;
      s1_rs_q     <= s1_rs_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign elem_cnt  = cnt_q;
  assign busy      = s0_valid_q | s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_dequantize_rescale.sv
// Bench for dequantize_rescale: reset, directed vector table, frame counter,
// backpressure, randomized stream against an arithmetic model, mid-stream reset.
// Define DEQ_SAT_EN here as for the design to check the saturating build.
module tb_dequantize_rescale;

  localparam int CW = 16;
  localparam longint I32_MAX = 64'sd2147483647;
  localparam longint I32_MIN = -64'sd2147483648;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic [31:0]   in_offset;
  logic [31:0]   in_multi;
  logic [31:0]   in_shift;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic [CW-1:0] elem_cnt;
  logic          busy;

  int            n_checks;
  int            n_fail;
  logic [32:0]   exp_q[$];
  logic          hold_pend;
  logic [32:0]   hold_val;
  int            ready_mode;
  int            pat_idx;

  typedef struct {
    logic [7:0]  d;
    logic [31:0] off;
    logic [31:0] mul;
    logic [31:0] sh;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  dequantize_rescale #(.FRAME_CNT_W(CW), .SHIFT_MAX(31)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_offset(in_offset), .in_multi(in_multi), .in_shift(in_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .elem_cnt(elem_cnt), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic following the rescale rules.
  function automatic logic [31:0] model(input logic [7:0] d, input logic [31:0] off,
                                        input logic [31:0] mul, input logic [31:0] sh);
    int     a, b, m, shv, ls, rs;
    longint wide, p, mag, q, r;
    a   = int'($signed(d)) + int'($signed(off));
    shv = $signed(sh);
    ls  = 0;
    rs  = 0;
    if (shv >= 0) ls = (shv > 31) ? 31 : shv;
    else          rs = (shv < -31) ? 31 : -shv;
    wide = longint'(a) * (longint'(1) << ls);
`ifdef DEQ_SAT_EN
    if (wide > I32_MAX)      b = int'(I32_MAX);
    else if (wide < I32_MIN) b = int'(I32_MIN);
    else                     b = int'(wide);
`else
    b = int'(wide);
`endif
    p = longint'(b) * longint'($signed(mul));
    m = int'((p + (longint'(1) << 31)) >>> 32);
`ifdef DEQ_SAT_EN
    if (longint'(b) == I32_MIN && longint'($signed(mul)) == I32_MIN) m = int'(I32_MAX);
`endif
    if (rs == 0) r = longint'(m);
    else begin
      mag = (m < 0) ? -longint'(m) : longint'(m);
      q   = (mag + (longint'(1) << (rs - 1))) >> rs;
      r   = (m < 0) ? -q : q;
    end
    return r[31:0];
  endfunction

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic drive_beat(input logic [7:0] d, input logic [31:0] off, input logic [31:0] mul,
                            input logic [31:0] sh, input logic last);
    int n;
    n         = 0;
    in_data   = d;
    in_offset = off;
    in_multi  = mul;
    in_shift  = sh;
    in_last   = last;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Ready shaper: pattern 1,0,0,1 or random, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) begin
      out_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
      pat_idx++;
    end else if (ready_mode == 2) begin
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_data_held", 64'({out_last, out_data}), 64'(hold_val));
      end
      if (out_valid && !out_ready) check("in_ready_low_on_stall", 64'(in_ready), 64'd0);
      hold_pend = out_valid & ~out_ready;
      hold_val  = {out_last, out_data};
      if (out_valid && out_ready) begin
        check("expect_available", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("scoreboard", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_last, model(in_data, in_offset, in_multi, in_shift)});
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int saw_valid;
    n_checks   = 0;
    n_fail     = 0;
    hold_pend  = 1'b0;
    hold_val   = '0;
    ready_mode = 0;
    pat_idx    = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    in_offset  = '0;
    in_multi   = '0;
    in_shift   = '0;
    out_ready  = 1'b0;

    vecs[0]  = '{8'd10,  32'd0,   32'h4000_0000, 32'd20,        32'd2621440};
    vecs[1]  = '{8'd20,  32'd0,   32'h4000_0000, 32'd0,         32'd5};
    vecs[2]  = '{8'hEC,  32'd0,   32'h4000_0000, 32'd0,         32'hFFFF_FFFB};
    vecs[3]  = '{8'd20,  32'd0,   32'h4000_0000, 32'hFFFF_FFFF, 32'd3};
    vecs[4]  = '{8'hEC,  32'd0,   32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5]  = '{8'h80,  32'd128, 32'h7FFF_FFFF, 32'd0,         32'd0};
    vecs[6]  = '{8'd5,   32'd0,   32'h4000_0000, 32'hFFFF_FFFF, 32'd1};
    vecs[7]  = '{8'hFF,  32'd0,   32'h4000_0000, 32'd0,         32'd0};
    vecs[8]  = '{8'd127, 32'd0,   32'h7FFF_FFFF, 32'd0,         32'd63};
    vecs[9]  = '{8'd0,   32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFD8, 32'd1};
`ifdef DEQ_SAT_EN
    vecs[10] = '{8'd100, 32'd0,   32'h4000_0000, 32'd40,        32'd536870912};
    vecs[11] = '{8'd127, 32'd0,   32'h7FFF_FFFF, 32'd30,        32'h3FFF_FFFF};
    vecs[12] = '{8'h80,  32'd0,   32'h8000_0000, 32'd24,        32'h7FFF_FFFF};
`else
    vecs[10] = '{8'd100, 32'd0,   32'h4000_0000, 32'd40,        32'd0};
    vecs[11] = '{8'd127, 32'd0,   32'h7FFF_FFFF, 32'd30,        32'hE000_0000};
    vecs[12] = '{8'h80,  32'd0,   32'h8000_0000, 32'd24,        32'h4000_0000};
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_elem_cnt", 64'(elem_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Frame counter: in_last on beat 5 clears the count.
    for (int k = 0; k < 5; k++) begin
      drive_beat(8'(k + 1), 32'd0, 32'h4000_0000, 32'd8, (k == 4));
      check($sformatf("elem_cnt_beat%0d", k + 1), 64'(elem_cnt), (k == 4) ? 64'd0 : 64'(k + 1));
    end
    drain("frame_drain");

    // Directed vectors with latency measured from the accepting edge.
    for (int i = 0; i < 13; i++) begin
      drive_beat(vecs[i].d, vecs[i].off, vecs[i].mul, vecs[i].sh, 1'b0);
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp));
      @(posedge clk);
      #1;
    end
    drain("vec_drain");

    // Backpressure: 8 beats with out_ready cycling 1,0,0,1.
    pat_idx    = 0;
    ready_mode = 1;
    for (int i = 0; i < 8; i++)
      drive_beat(8'(i * 13 - 50), 32'(i * 7), 32'h4000_0000, 32'd4, (i == 7));
    ready_mode = 0;
    drain("backpressure_drain");

    // Randomized stream with random downstream ready.
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        drive_beat(8'($urandom), ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300)),
                   $urandom, 32'($urandom_range(0, 80)) - 32'd40, ($urandom_range(0, 7) == 0));
      end
    end
    ready_mode = 0;
    drain("random_drain");

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) drive_beat(8'(k + 3), 32'd0, 32'h4000_0000, 32'd12, 1'b0);
    check("inflight_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_elem_cnt", 64'(elem_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    saw_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) saw_valid++;
    end
    check("no_stale_after_reset", 64'(saw_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dequantize_rescale.md
Name: dequantize_rescale

Overview:
- Input-side rescaler that is the reverse direction of the output requantizer.
- Accepts a stream of signed int8 activations and applies `x = (in_data + in_offset)`, then a pre-multiply left shift, a fixed-point multiply by `in_multi` (high word, rounded), and a rounding right shift.
- Emits signed int32 values on the same scale as the accumulator domain, for elementwise add/mul paths.
- Is a 3-stage stallable valid/ready pipeline with frame (`last`) tracking and an element counter.

Parameters:
- `FRAME_CNT_W`, 16, width of the accepted-element counter `elem_cnt`.
- `SHIFT_MAX`, 31, upper clip for any shift amount; larger magnitudes are clipped to this.

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept beat
- `in_data`  in  8  signed int8 activation
- `in_last`  in  1  final beat of frame
- `in_offset`  in  32  signed input offset
- `in_multi`  in  32  signed Q31 multiplier
- `in_shift`  in  32  signed shift; >=0 is left shift before multiply, <0 is right shift after multiply
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  32  signed int32 rescaled value
- `out_last`  out  1  `in_last` delayed with its beat
- `elem_cnt`  out  FRAME_CNT_W  beats accepted in current frame
- `busy`  out  1  any stage holds a valid beat

Behaviour:
- Reset: clock is `clk`; reset `rst` is asynchronous and active-high.
  - On `rst`, all stage valid bits, `out_valid`, `out_last`, `out_data` and `elem_cnt` go to 0; `busy`=0.
  - Reset mid-operation discards every in-flight beat; nothing is emitted for them.
- Config ports:
  - `in_offset`, `in_multi` and `in_shift` are quasi-static.
  - The block samples them into stage 0 alongside each beat, so a change takes effect on the next accepted beat.
  - In-flight beats keep their own values.
- Advance and handshake:
  - `adv = out_ready | ~out_valid`; `in_ready = adv`.
  - A beat is accepted when `in_valid & in_ready`.
  - All stages shift together when `adv`=1; when `adv`=0 every stage holds.
  - Bubbles (invalid stages) shift through only while `adv`=1.
- Latency: 3 cycles from acceptance to `out_valid` with no stalls. Sustained throughput is 1 beat/cycle.
- `out_data` and `out_last` are held stable while `out_valid & ~out_ready`.
- Stage 0:
  - `a = sext32(in_data) + in_offset`, with 32-bit wraparound.
  - `ls = (in_shift>=0) ? min(in_shift, SHIFT_MAX) : 0`.
  - `b = a << ls`, truncated to 32 bits.
- Stage 1:
  - `p = signed64(b) * signed64(multi)`.
  - `m = p[63:32] + p[31]` (round half up on the high word).
- Stage 2:
  - `rs = (in_shift<0) ? min(-in_shift, SHIFT_MAX) : 0`.
  - `mask = (1<<rs)-1`; `rem = m & mask`; `thr = (mask>>1) + m[31]`.
  - `out_data = (m >>> rs) + (rem > thr)`, i.e. round half away from zero.
  - With `rs=0` the result is `m` unchanged.
- `elem_cnt`:
  - Increments on each accepted beat.
  - On an accepted beat with `in_last`=1 it resets to 0 in the same cycle instead of incrementing.
  - Wraps modulo 2^FRAME_CNT_W.
- Simultaneous accept at input and output in one cycle is legal and is full throughput.
- `busy` = OR of the three stage valid bits.

Optional Feature:
- Macro: `DEQ_SAT_EN`.
- Defined:
  - Stage 0 left shift saturates to 0x7FFFFFFF / 0x80000000 when `a<<ls` overflows int32.
  - Stage 1 saturates the case `b = in_multi = 0x80000000` to `m = 0x7FFFFFFF`.
- Undefined: plain two's-complement wrap in both cases.

Test Plan:
- Basic scaling: `in_data`=10, `in_offset`=0, `in_shift`=+20, `in_multi`=0x40000000 -> `out_data`=2621440, arriving exactly 3 cycles after accept.
- Right-shift rounding: `in_data`=5, `in_offset`=0, `in_multi`=0x40000000, `in_shift`=-1 -> m=1 -> 1. Then `in_shift`=+2, `in_shift`=-1 variant cannot combine; use `in_data`=5, `in_shift`=-1, `in_multi`=0x7FFFFFFF...
  - Correction, use these instead: with `in_multi`=0x40000000 and pre-shift giving m=5 and m=-5 (via `in_data`=20/-20, `in_shift`=0), then `in_shift`=-1 -> `out_data`=3 and -3 respectively.
- Offset cancel: `in_data`=-128, `in_offset`=128, `in_multi`=0x7FFFFFFF, `in_shift`=0 -> `out_data`=0.
- Backpressure: stream 8 beats with `out_ready` toggling 1,0,0,1 pattern -> no beat lost or duplicated, `out_data` stable while stalled, order preserved, `in_ready` low whenever `out_valid & ~out_ready`.
- Frame/counter: 5 beats with `in_last` on beat 5 -> `elem_cnt` reads 1,2,3,4,0 after each accept; `out_last` high only on 5th output.
- Reset mid-stream: assert `rst` with 3 beats in flight -> `out_valid`=0 and `busy`=0 immediately (asynchronously); no stale output after reset release. With `DEQ_SAT_EN`, `in_data`=127, `in_shift`=+30 -> `out_data` reflects 0x7FFFFFFF pre-multiply.
